fetch_queue: RTL and testbench

Instruction fetch front end for the pipelined ARM core. It owns the fetch PC and issues word requests to instruction memory over a request/grant and response-valid handshake. Returned instructions are buffered in a small in-order prefetch queue, and the head entry is presented to the Fetch/Decode boundary as PCF/InstrF. Branch redirects from Execute flush the queue and discard in-flight responses, so stale instructions never reach Decode.

---
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue.sv | 127 ++++++++++++
 tb/tb_fetch_queue.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Instruction-memory request/response bundle between the fetch front end
// (master) and instruction memory (slave).
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues word requests to instruction
// memory under a credit limit, buffers returned instructions in an in-order
// prefetch queue and presents the head entry to Decode. A redirect flushes the
// queue and marks every in-flight response as stale so it is discarded.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_queue_if.master        imem,
    input  logic                 StallF,
    input  logic                 RedirectE,
    input  logic [31:0]          RedirectPC,
    output logic [31:0]          PCF,
    output logic [31:0]          InstrF,
    output logic                 ValidF
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam ptr_t PTR_ONE   = ptr_t'(1);
    localparam cnt_t CNT_ONE   = cnt_t'(1);
    localparam cnt_t CNT_DEPTH = cnt_t'(DEPTH);

    logic [31:0] r_fetchPc;
    logic [31:0] r_qPc    [DEPTH];
    logic [31:0] r_qInstr [DEPTH];
    ptr_t        r_rdPtr;
    ptr_t        r_wrPtr;
    cnt_t        r_occ;
    cnt_t        r_inflight;
    cnt_t        r_drop;

    logic [31:0] r_tagPc  [DEPTH];
    ptr_t        r_tagRd;
    ptr_t        r_tagWr;

    logic [CW:0] w_credit;
    logic        w_req;
    logic        w_grant;
    logic        w_valid;
    logic        w_pop;
    logic        w_push;
    logic        w_respDrop;
    logic        w_unusedPcBits;

    // Issue, pop and response-disposition decisions for the current cycle
    always_comb begin
        w_credit       = {1'b0, r_occ} + {1'b0, r_inflight};
        w_req          = reset & ~RedirectE & (w_credit < {1'b0, CNT_DEPTH});
        w_grant        = w_req & imem.imem_gnt;
        w_valid        = (r_occ != '0);
        w_pop          = w_valid & ~StallF & ~RedirectE;
        w_push         = imem.imem_rvalid & ~RedirectE & (r_drop == '0);
        w_respDrop     = imem.imem_rvalid & ~RedirectE & (r_drop != '0);
        w_unusedPcBits = ^RedirectPC[1:0];
    end

    // Fetch PC, queue pointers and the occupancy/in-flight/drop counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetchPc  <= RESET_PC;
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_occ      <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            r_tagRd    <= '0;
            r_tagWr    <= '0;
        end else begin
            r_inflight <= r_inflight + cnt_t'(w_grant) - cnt_t'(imem.imem_rvalid);
            if (w_grant) begin
                r_tagWr <= r_tagWr + PTR_ONE;
            end
            if (imem.imem_rvalid) begin
                r_tagRd <= r_tagRd + PTR_ONE;
            end
            if (RedirectE) begin
                r_fetchPc <= {RedirectPC[31:2], 2'b00};
                r_rdPtr   <= '0;
                r_wrPtr   <= '0;
                r_occ     <= '0;
                r_drop    <= r_inflight - cnt_t'(imem.imem_rvalid);
            end else begin
                if (w_grant) begin
                    r_fetchPc <= r_fetchPc + 32'd4;
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PTR_ONE;
                end
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PTR_ONE;
                end
                r_occ <= r_occ + cnt_t'(w_push) - cnt_t'(w_pop);
                if (w_respDrop) begin
                    r_drop <= r_drop - CNT_ONE;
                end
            end
        end
    end

    // Storage: request PC tags on grant, {pc, instr} entries on a kept response
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_tagPc[r_tagWr] <= r_fetchPc;
        end
        if (w_push) begin
            r_qPc[r_wrPtr]    <= r_tagPc[r_tagRd];
            r_qInstr[r_wrPtr] <= imem.imem_rdata;
        end
    end

    // Memory-side and Decode-side outputs; the head is zeroed when empty
    always_comb begin
        imem.imem_req  = w_req;
        imem.imem_addr = r_fetchPc;
        ValidF         = w_valid;
        PCF            = w_valid ? r_qPc[r_rdPtr]    : 32'h0;
        InstrF         = w_valid ? r_qInstr[r_rdPtr] : 32'h0;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a randomized instruction memory drives the fetch
// front end while a queue-based behavioural model predicts every output.
module tb_fetch_queue;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] XOR_KEY = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF;
    logic        RedirectE;
    logic [31:0] RedirectPC;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic        ValidF;

    fetch_queue_if bus ();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem       (bus),
        .StallF     (StallF),
        .RedirectE  (RedirectE),
        .RedirectPC (RedirectPC),
        .PCF        (PCF),
        .InstrF     (InstrF),
        .ValidF     (ValidF)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
    typedef struct { logic [31:0] pc; bit stale; } request_t;
    typedef struct { logic [31:0] addr; int ready; } pending_t;

    entry_t      modelQueue[$];
    request_t    modelOutstanding[$];
    logic [31:0] modelPc;
    pending_t    memPending[$];

    int          cycle;
    int          gntPct;
    int          rvPct;
    int          latMin;
    int          latMax;
    logic        stallIn;
    logic        redirIn;
    logic [31:0] redirPcIn;

    logic        sampReq;
    logic        sampValid;
    logic [31:0] sampPc;
    logic [31:0] sampInstr;

    int testsRun    = 0;
    int testsFailed = 0;

    // One comparison: counts it and reports a FAIL line on mismatch
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, actual, expected);
        end
    endtask

    // Compare DUT outputs against the model state for the current cycle
    task automatic checkOutput();
        logic expReq;
        int   staleCount;
        sampReq   = bus.imem_req;
        sampValid = ValidF;
        sampPc    = PCF;
        sampInstr = InstrF;
        expReq = !redirIn && ((modelQueue.size() + modelOutstanding.size()) < DEPTH);
        check("imem_req", 32'(sampReq), 32'(expReq));
        if (expReq) begin
            check("imem_addr", bus.imem_addr, modelPc);
        end
        check("ValidF", 32'(sampValid), 32'(modelQueue.size() != 0));
        check("PCF", sampPc, (modelQueue.size() != 0) ? modelQueue[0].pc : 32'h0);
        check("InstrF", sampInstr, (modelQueue.size() != 0) ? modelQueue[0].instr : 32'h0);
        staleCount = 0;
        foreach (modelOutstanding[i]) begin
            if (modelOutstanding[i].stale) staleCount++;
        end
        check("drop count", 32'(dut.r_drop), 32'(staleCount));
        check("credit bound", 32'((32'(dut.r_occ) + 32'(dut.r_inflight)) <= 32'(DEPTH)), 32'd1);
    endtask

    // Advance the model across the coming clock edge from the spec's rules
    task automatic modelUpdate();
        logic     mReq;
        request_t req;
        mReq = !redirIn && ((modelQueue.size() + modelOutstanding.size()) < DEPTH);
        if (redirIn) begin
            modelQueue.delete();
            if (bus.imem_rvalid && modelOutstanding.size() != 0) begin
                void'(modelOutstanding.pop_front());
            end
            foreach (modelOutstanding[i]) modelOutstanding[i].stale = 1'b1;
            modelPc = {redirPcIn[31:2], 2'b00};
        end else begin
            if (modelQueue.size() != 0 && !stallIn) begin
                void'(modelQueue.pop_front());
            end
            if (bus.imem_rvalid && modelOutstanding.size() != 0) begin
                req = modelOutstanding.pop_front();
                if (!req.stale) modelQueue.push_back(entry_t'{req.pc, bus.imem_rdata});
            end
            if (mReq && bus.imem_gnt) begin
                modelOutstanding.push_back(request_t'{modelPc, 1'b0});
                modelPc = modelPc + 32'd4;
            end
        end
    endtask

    // Drive one cycle of inputs and memory behaviour, check, then step the model
    task automatic applyStimulus();
        int lat;
        StallF     = stallIn;
        RedirectE  = redirIn;
        RedirectPC = redirPcIn;
        bus.imem_gnt = (int'($urandom_range(99)) < gntPct);
        if (memPending.size() != 0 && memPending[0].ready <= cycle && int'($urandom_range(99)) < rvPct) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memPending[0].addr ^ XOR_KEY;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        #1;
        checkOutput();
        if (bus.imem_rvalid) void'(memPending.pop_front());
        if (bus.imem_req && bus.imem_gnt) begin
            lat = int'($urandom_range(latMax, latMin));
            memPending.push_back(pending_t'{bus.imem_addr, cycle + lat});
        end
        modelUpdate();
        cycle++;
        @(negedge clk);
    endtask

    // Assert reset off the clock edge, check the cleared outputs, release on a negedge
    task automatic applyReset();
        @(negedge clk);
        #2;
        reset           = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        StallF          = 1'b0;
        RedirectE       = 1'b0;
        RedirectPC      = 32'h0;
        #1;
        check("reset imem_req", 32'(bus.imem_req), 32'h0);
        check("reset ValidF", 32'(ValidF), 32'h0);
        check("reset PCF", PCF, 32'h0);
        check("reset InstrF", InstrF, 32'h0);
        modelQueue.delete();
        modelOutstanding.delete();
        memPending.delete();
        modelPc = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cycle = 0;
    endtask

    initial begin
        logic [31:0] seen[$];
        bit          found;
        reset     = 1'b0;
        stallIn   = 1'b0;
        redirIn   = 1'b0;
        redirPcIn = 32'h0;
        gntPct    = 100;
        rvPct     = 100;
        latMin    = 1;
        latMax    = 1;
        cycle     = 0;

        applyReset();

        for (int c = 0; c < 12; c++) begin
            applyStimulus();
            if (c == 0) begin
                check("first request", 32'(sampReq), 32'd1);
            end
            if (c < 2) begin
                check("zero-wait early ValidF", 32'(sampValid), 32'd0);
            end else begin
                check("zero-wait ValidF", 32'(sampValid), 32'd1);
                check("zero-wait PCF", sampPc, 32'(4 * (c - 2)));
                check("zero-wait InstrF", sampInstr, 32'(4 * (c - 2)) ^ XOR_KEY);
            end
        end

        stallIn = 1'b1;
        repeat (10) applyStimulus();
        check("stall saturates req", 32'(sampReq), 32'd0);
        check("stall holds PCF", sampPc, 32'd40);
        stallIn = 1'b0;
        repeat (6) applyStimulus();

        latMin = 3;
        latMax = 3;
        repeat (6) applyStimulus();
        redirIn   = 1'b1;
        redirPcIn = 32'h0000_0103;
        applyStimulus();
        redirIn = 1'b0;
        found   = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            applyStimulus();
            if (sampValid) begin
                found = 1'b1;
                check("redirect target PCF", sampPc, 32'h0000_0100);
                check("redirect target InstrF", sampInstr, 32'h0000_0100 ^ XOR_KEY);
            end
        end
        check("redirect target arrives", 32'(found), 32'd1);

        latMin = 1;
        latMax = 1;
        repeat (8) applyStimulus();
        redirIn   = 1'b1;
        redirPcIn = 32'hFFFF_FFF8;
        applyStimulus();
        redirIn = 1'b0;
        applyStimulus();
        check("flush empties queue", 32'(sampValid), 32'd0);
        for (int c = 0; c < 30 && seen.size() < 3; c++) begin
            applyStimulus();
            if (sampValid) seen.push_back(sampPc);
        end
        check("wrap sequence length", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            check("wrap PC 0", seen[0], 32'hFFFF_FFF8);
            check("wrap PC 1", seen[1], 32'hFFFF_FFFC);
            check("wrap PC 2", seen[2], 32'h0000_0000);
        end

        gntPct = 70;
        rvPct  = 70;
        latMin = 1;
        latMax = 4;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) applyReset();
            stallIn = (int'($urandom_range(99)) < 30);
            redirIn = (int'($urandom_range(99)) < 3);
            if (int'($urandom_range(3)) == 0) begin
                redirPcIn = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            end else begin
                redirPcIn = $urandom;
            end
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
